ai_scan_m: RTL

- Clocked, parametrised AI move generator for an N×N board.
- On the AI's turn it snapshots the board and scans it one cell per clock, picking a move by strategy mode: first-blank, or win > block > centre > first-blank.
- It then presents the move to the board with a submit/ack handshake.
- Drives the board's shared update bus through tri-state buffers gated by turn. It also requests a board reset when no blank cell remains.

---
 rtl/ai_scan_m_pkg.sv | 25 ++
 rtl/ai_line_check_m.sv | 48 ++++
 rtl/ai_scan_m.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ai_scan_m_pkg.sv
// Shared encodings for the AI move generator: cell values, bus ownership,
// scan FSM states and move priorities.
package ai_scan_m_pkg;

  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic TURN_AI = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SUBMIT = 2'd2,
    FULL   = 2'd3
  } state_t;

  typedef logic [1:0] pri_t;

  localparam pri_t PRI_WIN    = 2'd3;
  localparam pri_t PRI_BLOCK  = 2'd2;
  localparam pri_t PRI_CENTRE = 2'd1;
  localparam pri_t PRI_BLANK  = 2'd0;

endpackage

// File: rtl/ai_line_check_m.sv
// Combinational test: would placing `piece` at cell idx complete the row,
// column or a diagonal through idx, given the other cells of snap?
module ai_line_check_m
  import ai_scan_m_pkg::*;
#(
  parameter int SIDE    = 3,
  parameter int INDEX_W = $clog2(SIDE*SIDE)
) (
  input  logic [2*SIDE*SIDE-1:0] snap,
  input  logic [INDEX_W-1:0]     idx,
  input  logic [1:0]             piece,
  output logic                   completes
);

  localparam int NC = SIDE*SIDE;

  logic [INDEX_W-1:0] r;
  logic [INDEX_W-1:0] c;
  logic [NC-1:0]      row_bad;
  logic [NC-1:0]      col_bad;
  logic [NC-1:0]      diag_bad;
  logic [NC-1:0]      anti_bad;

  assign r = idx / INDEX_W'(SIDE);
  assign c = idx % INDEX_W'(SIDE);

  // Per-cell flags use elaboration-time coordinates so no cell is indexed by idx.
  for (genvar j = 0; j < NC; j++) begin : g_cell
    localparam logic [INDEX_W-1:0] JR = INDEX_W'(j / SIDE);
    localparam logic [INDEX_W-1:0] JC = INDEX_W'(j % SIDE);
    localparam bit ON_DIAG = ((j / SIDE) == (j % SIDE));
    localparam bit ON_ANTI = ((j / SIDE) + (j % SIDE) == SIDE - 1);

    logic other_mismatch;
    assign other_mismatch = (snap[2*j +: 2] != piece) && (idx != INDEX_W'(j));

    assign row_bad[j]  = other_mismatch && (JR == r);
    assign col_bad[j]  = other_mismatch && (JC == c);
    assign diag_bad[j] = other_mismatch && ON_DIAG;
    assign anti_bad[j] = other_mismatch && ON_ANTI;
  end

  assign completes = !(|row_bad)
                  || !(|col_bad)
                  || ((r == c) && !(|diag_bad))
                  || (((r + c) == INDEX_W'(SIDE - 1)) && !(|anti_bad));

endmodule

// File: rtl/ai_scan_m.sv
// AI move generator: snapshots the board on the AI's turn, scans one cell per
// clock for the best move and offers it on the shared, turn-gated update bus.
module ai_scan_m
  import ai_scan_m_pkg::*;
#(
  parameter int SIDE    = 3,
  parameter int MODE    = 1,
  parameter int INDEX_W = $clog2(SIDE*SIDE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*SIDE*SIDE-1:0] board_state,
  input  logic                   turn,
  input  logic                   submit_ack,
  output logic [INDEX_W-1:0]     update_loc,
  output logic [1:0]             update_val,
  output logic                   submit,
  output logic                   board_reset,
  output logic                   busy
);

  localparam int NC = SIDE*SIDE;
  localparam logic [INDEX_W-1:0] LAST_IDX   = INDEX_W'(NC - 1);
  localparam logic [INDEX_W-1:0] CENTRE_IDX = INDEX_W'(NC / 2);
  localparam bit HAS_CENTRE = (SIDE % 2) == 1;

  state_t             state;
  logic               turn_d;
  logic [2*NC-1:0]    snap;
  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] best_loc;
  pri_t               best_pri;
  logic               found;
  logic               done;
  logic [INDEX_W-1:0] loc_q;
  logic               submit_q;
  logic               board_reset_q;
  logic               busy_q;

  logic [1:0] snap_cells [NC];
  logic       cur_blank;
  logic       o_wins;
  logic       x_wins;
  pri_t       cur_pri;
  logic       take;

  for (genvar j = 0; j < NC; j++) begin : g_cells
    assign snap_cells[j] = snap[2*j +: 2];
  end

  ai_line_check_m #(.SIDE(SIDE), .INDEX_W(INDEX_W)) u_check_o (
    .snap      (snap),
    .idx       (idx),
    .piece     (CELL_O),
    .completes (o_wins)
  );

  ai_line_check_m #(.SIDE(SIDE), .INDEX_W(INDEX_W)) u_check_x (
    .snap      (snap),
    .idx       (idx),
    .piece     (CELL_X),
    .completes (x_wins)
  );

  assign cur_blank = (snap_cells[idx] == CELL_BLANK);

  always_comb begin
    cur_pri = PRI_BLANK;
    if (MODE != 0) begin
      if (o_wins)                              cur_pri = PRI_WIN;
      else if (x_wins)                         cur_pri = PRI_BLOCK;
      else if (HAS_CENTRE && idx == CENTRE_IDX) cur_pri = PRI_CENTRE;
    end
  end

  // Strictly-greater replacement keeps the lowest index on equal priority.
  assign take = cur_blank && (!found || (cur_pri > best_pri));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      turn_d        <= 1'b0;
      snap          <= '0;
      idx           <= '0;
      best_loc      <= '0;
      best_pri      <= PRI_BLANK;
      found         <= 1'b0;
      done          <= 1'b0;
      loc_q         <= '0;
      submit_q      <= 1'b0;
      board_reset_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      turn_d <= turn;
      case (state)
        IDLE: begin
          if (turn == TURN_AI && turn_d != TURN_AI) begin
            snap     <= board_state;
            idx      <= '0;
            best_pri <= PRI_BLANK;
            best_loc <= '0;
            found    <= 1'b0;
            done     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (turn != TURN_AI) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (done) begin
            // Decision cycle after the last evaluated cell.
            if (found) begin
              loc_q    <= best_loc;
              submit_q <= 1'b1;
              state    <= SUBMIT;
            end else begin
              board_reset_q <= 1'b1;
              busy_q        <= 1'b0;
              state         <= FULL;
            end
          end else begin
            if (take) begin
              best_pri <= cur_pri;
              best_loc <= idx;
              found    <= 1'b1;
            end
            if (idx == LAST_IDX || (MODE == 0 && take)) done <= 1'b1;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        SUBMIT: begin
          if (turn != TURN_AI || submit_ack) begin
            submit_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        FULL: begin
          board_reset_q <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign update_loc  = (turn == TURN_AI) ? loc_q         : 'z;
  assign update_val  = (turn == TURN_AI) ? CELL_O        : 'z;
  assign submit      = (turn == TURN_AI) ? submit_q      : 1'bz;
  assign board_reset = (turn == TURN_AI) ? board_reset_q : 1'bz;
  assign busy        = busy_q;

endmodule
